// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive control FSM.
package serial_rx_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_SHIFT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    STOP,
    VALID,
    ERR
  } state_t;

  // Watchdog must be able to hold MAX_SHIFT itself, since it saturates there.
  function automatic int wd_width(input int max_shift);
    return $clog2(max_shift + 1);
  endfunction

endpackage

// File: rtl/serial_rx_ctrl.sv
// Receive control FSM: start-bit detect, shift sequencing, stop-bit check,
// byte holding register with valid/ready handshake, and a missing-CO watchdog.
module serial_rx_ctrl
  import serial_rx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF  // must exceed DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SerI,
  input  logic              CO,
  input  logic [DATA_W-1:0] Reg_Out,
  output logic              En_reg,
  output logic              Init_Reg,
  output logic              Init_Cnt,
  output logic              Inc_Cnt,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Valid,
  input  logic              Ready,
  output logic              Frame_Err,
  output logic              Overrun,
  input  logic              Clr_Ovr,
  output logic              Busy
);

  localparam int WD_W = wd_width(MAX_SHIFT);

  state_t          state;
  state_t          state_d;
  logic [WD_W-1:0] wd;
  logic            wd_expired;
  logic            wd_saturated;

  assign wd_expired   = (wd == WD_W'(MAX_SHIFT - 1));
  assign wd_saturated = (wd == WD_W'(MAX_SHIFT));

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!SerI) state_d = INIT;
      INIT:    state_d = SHIFT;
      SHIFT: begin
        if (CO)              state_d = STOP;
        else if (wd_expired) state_d = ERR;
      end
      STOP:    state_d = SerI ? VALID : ERR;
      VALID:   if (Ready) state_d = IDLE;
      ERR:     if (SerI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: outputs are decoded from the next state and registered, so each one is
  // a glitch-free Moore output that is valid for exactly the cycles spent in that state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      wd        <= '0;
      Data_Out  <= '0;
      Init_Reg  <= 1'b0;
      Init_Cnt  <= 1'b0;
      En_reg    <= 1'b0;
      Inc_Cnt   <= 1'b0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      Init_Reg  <= (state_d == INIT);
      Init_Cnt  <= (state_d == INIT);
      En_reg    <= (state_d == SHIFT);
      Inc_Cnt   <= (state_d == SHIFT);
      Valid     <= (state_d == VALID);
      Busy      <= (state_d != IDLE);
      Frame_Err <= (state_d == ERR) && (state != ERR);

      if (state == INIT)
        wd <= '0;
      else if (state == SHIFT && !wd_saturated)
        wd <= wd + WD_W'(1);

      if (state == STOP && SerI)
        Data_Out <= Reg_Out;

      // A start bit arriving while the held byte is still unclaimed is lost.
      if (Clr_Ovr)
        Overrun <= 1'b0;
      else if (Valid && !Ready && !SerI)
        Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl with a behavioural LSB-first shift/count datapath.
module tb_serial_rx_ctrl;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          SerI;
  logic          CO;
  logic          Ready;
  logic          Clr_Ovr;
  logic [DW-1:0] Reg_Out;
  logic [DW-1:0] Data_Out;
  logic          En_reg, Init_Reg, Init_Cnt, Inc_Cnt;
  logic          Valid, Frame_Err, Overrun, Busy;

  logic [DW-1:0] dp_reg;
  logic [3:0]    dp_cnt;
  logic [1:0]    co_mode;  // 0: datapath CO, 1: tied low, 2: forced by co_frc
  logic          co_frc;
  logic          dp_co;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc, n_init, n_icnt, n_en, n_inc, n_val, n_ferr, valid_cyc;

  serial_rx_ctrl #(.DATA_W(DW), .MAX_SHIFT(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .SerI      (SerI),
    .CO        (CO),
    .Reg_Out   (Reg_Out),
    .En_reg    (En_reg),
    .Init_Reg  (Init_Reg),
    .Init_Cnt  (Init_Cnt),
    .Inc_Cnt   (Inc_Cnt),
    .Data_Out  (Data_Out),
    .Valid     (Valid),
    .Ready     (Ready),
    .Frame_Err (Frame_Err),
    .Overrun   (Overrun),
    .Clr_Ovr   (Clr_Ovr),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // Datapath model: first received bit ends up in bit 0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dp_reg <= '0;
      dp_cnt <= '0;
    end else begin
      if (Init_Reg)    dp_reg <= '0;
      else if (En_reg) dp_reg <= {SerI, dp_reg[DW-1:1]};
      if (Init_Cnt)     dp_cnt <= '0;
      else if (Inc_Cnt) dp_cnt <= dp_cnt + 4'd1;
    end
  end

  assign dp_co   = En_reg && (dp_cnt == 4'd7);
  assign CO      = (co_mode == 2'd0) ? dp_co : (co_mode == 2'd2) ? co_frc : 1'b0;
  assign Reg_Out = dp_reg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    n_init += int'(Init_Reg);
    n_icnt += int'(Init_Cnt);
    n_en   += int'(En_reg);
    n_inc  += int'(Inc_Cnt);
    n_val  += int'(Valid);
    n_ferr += int'(Frame_Err);
    if (Valid && valid_cyc == 0) valid_cyc = cyc;
  endtask

  task automatic clear();
    cyc = 0; n_init = 0; n_icnt = 0; n_en = 0; n_inc = 0;
    n_val = 0; n_ferr = 0; valid_cyc = 0;
  endtask

  // Start bit, one unsampled cycle while INIT clears the datapath, then b[7] first.
  task automatic send_data(input logic [7:0] b);
    SerI = 1'b0; step();
    SerI = b[7]; step();
    for (int k = 7; k >= 0; k--) begin
      SerI = b[k];
      step();
    end
  endtask

  initial begin
    Rst = 1'b1; SerI = 1'b1; Ready = 1'b1; Clr_Ovr = 1'b0;
    co_mode = 2'd0; co_frc = 1'b0;
    clear();
    step(); step();
    check("rst_busy",    32'(Busy),     32'd0);
    check("rst_valid",   32'(Valid),    32'd0);
    check("rst_data",    32'(Data_Out), 32'd0);
    check("rst_en",      32'(En_reg),   32'd0);
    check("rst_overrun", 32'(Overrun),  32'd0);
    Rst = 1'b0;
    step(); step();

    // Good frame, consumer ready on arrival
    clear();
    send_data(8'b1011_0111);
    SerI = 1'b1; step();
    check("t1_init_reg", 32'(n_init),   32'd1);
    check("t1_init_cnt", 32'(n_icnt),   32'd1);
    check("t1_en_cycles", 32'(n_en),    32'd8);
    check("t1_inc_cycles", 32'(n_inc),  32'd8);
    check("t1_valid_lat", 32'(valid_cyc), 32'd11);
    check("t1_data",     32'(Data_Out), 32'hED);
    step();
    check("t1_valid_drop", 32'(Valid),  32'd0);
    check("t1_idle",     32'(Busy),     32'd0);
    check("t1_valid_cnt", 32'(n_val),   32'd1);
    check("t1_ferr_cnt", 32'(n_ferr),   32'd0);

    // Bad stop bit, line then held low
    clear();
    send_data(8'b1011_0111);
    SerI = 1'b0; step();
    check("t2_ferr_pulse", 32'(Frame_Err), 32'd1);
    repeat (5) step();
    check("t2_err_hold",  32'(Busy),      32'd1);
    check("t2_ferr_once", 32'(n_ferr),    32'd1);
    check("t2_no_valid",  32'(n_val),     32'd0);
    check("t2_data_kept", 32'(Data_Out),  32'hED);
    SerI = 1'b1; step();
    check("t2_back_idle", 32'(Busy),      32'd0);

    // Missing CO: watchdog expires on the 16th SHIFT cycle
    co_mode = 2'd1;
    clear();
    SerI = 1'b0; step();
    SerI = 1'b1; step();
    repeat (15) step();
    check("t3_still_shift", 32'(En_reg),   32'd1);
    check("t3_no_err_yet",  32'(Frame_Err), 32'd0);
    step();
    check("t3_en_drop",   32'(En_reg),    32'd0);
    check("t3_ferr",      32'(Frame_Err), 32'd1);
    check("t3_en_cycles", 32'(n_en),      32'd16);
    step();
    check("t3_ferr_end",  32'(Frame_Err), 32'd0);
    check("t3_idle",      32'(Busy),      32'd0);
    co_mode = 2'd0;

    // Consumer stalls; a new start bit during the stall raises Overrun
    Ready = 1'b0;
    clear();
    send_data(8'b0101_1001);
    SerI = 1'b1; step();
    check("t4_valid",     32'(Valid),     32'd1);
    check("t4_data",      32'(Data_Out),  32'h9A);
    repeat (4) step();
    SerI = 1'b0; Clr_Ovr = 1'b1; step();
    check("t4_clr_wins",  32'(Overrun),   32'd0);
    Clr_Ovr = 1'b0; step();
    check("t4_ovr_set",   32'(Overrun),   32'd1);
    check("t4_stay_valid", 32'(Valid),    32'd1);
    SerI = 1'b1;
    repeat (14) step();
    check("t4_ovr_sticky", 32'(Overrun),  32'd1);
    check("t4_data_stable", 32'(Data_Out), 32'h9A);
    check("t4_valid_cnt", 32'(n_val),     32'd21);
    Ready = 1'b1; step();
    check("t4_handshake", 32'(Valid),     32'd0);
    check("t4_idle",      32'(Busy),      32'd0);
    check("t4_ovr_kept",  32'(Overrun),   32'd1);
    Clr_Ovr = 1'b1; step();
    Clr_Ovr = 1'b0;
    check("t4_ovr_clr",   32'(Overrun),   32'd0);

    // Async reset in the 4th SHIFT cycle, then a clean frame
    clear();
    SerI = 1'b0; step();
    SerI = 1'b1;
    repeat (4) step();
    check("t5_in_shift",  32'(En_reg),    32'd1);
    Rst = 1'b1;
    #1;
    check("t5_async_en",  32'(En_reg),    32'd0);
    check("t5_async_inc", 32'(Inc_Cnt),   32'd0);
    check("t5_async_busy", 32'(Busy),     32'd0);
    check("t5_async_data", 32'(Data_Out), 32'd0);
    step();
    Rst = 1'b0;
    step();
    check("t5_no_valid",  32'(n_val),     32'd0);
    check("t5_no_ferr",   32'(n_ferr),    32'd0);
    clear();
    send_data(8'b0101_1001);
    SerI = 1'b1; step();
    check("t5_rx_valid",  32'(Valid),     32'd1);
    check("t5_rx_data",   32'(Data_Out),  32'h9A);
    step();

    // CO arrives in the very cycle the watchdog would expire
    co_mode = 2'd2; co_frc = 1'b0;
    clear();
    SerI = 1'b0; step();
    SerI = 1'b1; step();
    repeat (15) step();
    co_frc = 1'b1; step();
    co_frc = 1'b0;
    check("t6_no_ferr",   32'(Frame_Err), 32'd0);
    check("t6_stop_busy", 32'(Busy),      32'd1);
    check("t6_stop_en",   32'(En_reg),    32'd0);
    step();
    check("t6_valid",     32'(Valid),     32'd1);
    check("t6_ferr_cnt",  32'(n_ferr),    32'd0);
    step();
    check("t6_idle",      32'(Busy),      32'd0);
    co_mode = 2'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
- Control FSM for the serial receive datapath (BitCounter: shift register plus bit counter with carry-out CO).
- Detects a start bit on SerI and drives Init_Reg/Init_Cnt/En_reg/Inc_Cnt.
- Ends the frame on CO, checks the stop bit, latches Reg_Out into a holding register and presents it on a valid/ready handshake.
- Watchdog guards against a missing CO.

Parameters:
DATA_W, 8, frame payload width; matches the datapath register width.
MAX_SHIFT, 16, SHIFT cycles allowed without CO before timeout error; must be > DATA_W.

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
SerI  input  1  serial line; idles high, start bit 0, stop bit 1
CO  input  1  datapath counter carry-out; high in the cycle the last data bit is shifted
Reg_Out  input  DATA_W  datapath shift-register contents
En_reg  output  1  datapath shift enable
Init_Reg  output  1  datapath register clear
Init_Cnt  output  1  datapath counter clear
Inc_Cnt  output  1  datapath counter increment
Data_Out  output  DATA_W  held received byte
Valid  output  1  Data_Out is valid
Ready  input  1  consumer accepts Data_Out when Valid&&Ready
Frame_Err  output  1  one-cycle pulse on stop-bit error or watchdog timeout
Overrun  output  1  sticky flag: start bit seen while Valid&&!Ready
Clr_Ovr  input  1  synchronous clear of Overrun
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, Rst=1): state=IDLE; all outputs 0; Data_Out=0; watchdog=0. Reset mid-frame aborts the frame; no Valid or Frame_Err is produced.
- Datapath controls are Moore outputs of state only.
- IDLE:
  - all controls 0.
  - SerI==0 at a clock edge -> INIT.
- INIT (exactly 1 cycle):
  - Init_Reg=1, Init_Cnt=1.
  - -> SHIFT; watchdog cleared.
- SHIFT:
  - En_reg=1, Inc_Cnt=1; watchdog increments each cycle.
  - CO==1 -> STOP. That cycle's shift is the last bit.
  - Else watchdog==MAX_SHIFT-1 -> ERR.
  - CO takes priority over timeout in the same cycle.
- STOP (1 cycle, all controls 0):
  - SerI==1: Data_Out<=Reg_Out -> VALID.
  - SerI==0: -> ERR.
- VALID:
  - Valid=1; Data_Out stable.
  - Valid&&Ready at an edge: transfer done -> IDLE; Valid is 0 in the next cycle.
  - Ready may be high on arrival, giving a 1-cycle Valid.
  - SerI==0 while Valid&&!Ready: Overrun<=1; the frame is not received and the FSM stays in VALID.
- ERR:
  - Frame_Err=1 on the first ERR cycle only.
  - Stays in ERR until SerI==1 -> IDLE. A line held low never restarts.
- Overrun: cleared by Clr_Ovr (Clr_Ovr wins over a same-cycle set) or by Rst.
- Latency: start-bit edge to INIT is 1 cycle. With DATA_W=8 and a CO-on-8th-shift datapath, the start edge to the Valid rising edge is 1+1+8+1 = 11 cycles.
- Watchdog width: $clog2(MAX_SHIFT+1); it never wraps.

Decomposition:
- Package serial_rx_pkg holds:
  - state enum {IDLE, INIT, SHIFT, STOP, VALID, ERR}
  - DATA_W default constant
  - watchdog width function
- No sub-module needed. The watchdog counter and holding register stay inline.
- Top-level receiver is this block plus BitCounter.

Test Plan:
- Frame 0,{1,0,1,1,0,1,1,1},1 into BitCounter with Ready=1 -> Init pulses 1 cycle; En_reg/Inc_Cnt high 8 cycles; Valid 1 cycle at cycle 11; Data_Out equals Reg_Out at STOP (0xB7 or bit-reverse 0xED per datapath shift order); Frame_Err=0.
- Same frame but stop bit 0 -> Frame_Err exactly 1 cycle, Valid never rises; SerI held low 5 cycles keeps ERR; SerI=1 -> IDLE next cycle.
- CO tied 0 -> timeout after 16 SHIFT cycles; Frame_Err pulse; En_reg drops to 0.
- Ready=0 for 20 cycles after Valid, second start bit during the wait -> Overrun=1 stays set; Data_Out unchanged; Ready=1 -> IDLE; Clr_Ovr -> Overrun=0.
- Rst pulse in the 4th SHIFT cycle -> all outputs 0 immediately (async); a new full frame afterwards receives correctly.
- CO and watchdog terminal in the same cycle (MAX_SHIFT=DATA_W force) -> STOP taken, no Frame_Err.
